// File: rtl/majority_bundler_pkg.sv
// Shared HPU definitions: default vector/counter sizes and the bundler FSM state encoding.
package hpu_pkg;

  localparam int DIM_DEF   = 1023;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/majority_bundler_if.sv
// Core-to-bundler stream and bundled-result return path.
interface majority_bundler_if #(
  parameter int DIM   = hpu_pkg::DIM_DEF,
  parameter int CNT_W = hpu_pkg::CNT_W_DEF
);

  logic             run;
  logic             store;
  logic [DIM:0]     core_result;
  logic             last;
  logic [DIM:0]     tie_rand;
  logic [DIM:0]     sign_bit;
  logic             sign_valid;
  logic [CNT_W-1:0] vec_cnt;
  logic             ovf;

  modport master (
    output run, store, core_result, last, tie_rand,
    input  sign_bit, sign_valid, vec_cnt, ovf
  );

  modport slave (
    input  run, store, core_result, last, tie_rand,
    output sign_bit, sign_valid, vec_cnt, ovf
  );

endinterface

// File: rtl/majority_bundler_sat_bit_counter.sv
// Single saturating ones counter for one hypervector dimension; sat flags the ceiling.
module sat_bit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/majority_bundler.sv
// Majority bundler: counts ones per dimension over stored vectors, thresholds on last.
// Build option HPU_TIE_RAND_EN: ties take tie_rand[i] instead of resolving to 0.
module majority_bundler
  import hpu_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  majority_bundler_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] vec_cnt;
  logic [DIM:0]     sign_bit;
  logic             sign_valid;
  logic             ovf;

  logic [CNT_W-1:0] ones [DIM+1];
  logic [DIM:0]     inc_v;
  logic [DIM:0]     sat_v;
  logic [DIM:0]     tie_v;
  logic [DIM:0]     maj_v;
  logic             clr;
  logic             acc_en;
  logic             vec_sat;
  logic             ovf_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // 2*ones vs vec_cnt in CNT_W+1 bits: strict majority wins, exact half is a tie
  function automatic logic maj_bit(input logic [CNT_W-1:0] ones_i,
                                   input logic [CNT_W-1:0] total,
                                   input logic             tie);
    logic [CNT_W:0] lhs;
    logic [CNT_W:0] rhs;
    lhs = {ones_i, 1'b0};
    rhs = {1'b0, total};
    if (lhs > rhs)      return 1'b1;
    else if (lhs < rhs) return 1'b0;
    else                return tie;
  endfunction

  assign clr     = ~bus.run;
  assign acc_en  = bus.run && (state == ACC) && bus.store;
  assign inc_v   = acc_en ? bus.core_result : '0;
  assign vec_sat = &vec_cnt;
  assign ovf_hit = acc_en && (vec_sat || (|(inc_v & sat_v)));

`ifdef HPU_TIE_RAND_EN
  assign tie_v = bus.tie_rand;
`else
  logic unused_tie;
  assign tie_v      = '0;
  assign unused_tie = ^bus.tie_rand;
`endif

  for (genvar g = 0; g <= DIM; g++) begin : g_cnt
    sat_bit_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc(inc_v[g]),
      .cnt(ones[g]),
      .sat(sat_v[g])
    );
  end

  always_comb begin
    maj_v = '0;
    for (int i = 0; i <= DIM; i++) begin
      maj_v[i] = maj_bit(ones[i], vec_cnt, tie_v[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec_cnt    <= '0;
      sign_bit   <= '0;
      sign_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (!bus.run) begin
      state      <= IDLE;
      vec_cnt    <= '0;
      sign_bit   <= '0;
      sign_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ACC;
        ACC: begin
          if (bus.store) begin
            vec_cnt <= sat_inc(vec_cnt);
            ovf     <= ovf | ovf_hit;
          end
          if (bus.last) state <= CALC;
        end
        CALC: begin
          sign_bit   <= maj_v;
          sign_valid <= 1'b1;
          state      <= DONE;
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sign_bit   = sign_bit;
  assign bus.sign_valid = sign_valid;
  assign bus.vec_cnt    = vec_cnt;
  assign bus.ovf        = ovf;

endmodule
